vram_slot_arbiter: RTL

Parametrised VRAM slot arbiter for the VDP memory port, generalising the fixed display/sprite/CPU/command arbitration to N toggle-handshake clients. On each access slot strobe it grants the slot to the display engine if claimed, otherwise to one pending client. The fixed priority order gains starvation promotion. It drives the registered VRAM address/data/write-enable bus between the VDP pipelines and the memory controller.

---
 rtl/vram_arb_pkg.sv | 15 +
 rtl/vram_arb_pick.sv | 33 +++
 rtl/vram_slot_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM slot arbiter: write size codes and grant-id helpers.
package vram_arb_pkg;

    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] MEM_WIDTH_8  = 2'd0;
    localparam logic [SIZE_W-1:0] MEM_WIDTH_16 = 2'd1;
    localparam logic [SIZE_W-1:0] MEM_WIDTH_32 = 2'd2;

    // The display engine is reported as the index one past the last client.
    function automatic int unsigned display_grant_id(input int unsigned num_clients);
        return num_clients;
    endfunction

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational client picker: starved pending clients win over plain pending ones,
// lowest index first within each class.
module vram_arb_pick
    import vram_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    localparam int unsigned ID_W = $clog2(NUM_CLIENTS + 1)
) (
    input  logic [NUM_CLIENTS-1:0] pending,
    input  logic [NUM_CLIENTS-1:0] starved,
    output logic [NUM_CLIENTS-1:0] grant_oh,
    output logic [ID_W-1:0]        grant_idx
);

    logic [NUM_CLIENTS-1:0] promoted;
    logic [NUM_CLIENTS-1:0] cand;

    always_comb begin
        promoted  = pending & starved;
        cand      = (|promoted) ? promoted : pending;
        grant_oh  = '0;
        grant_idx = '0;
        // Scan high to low so the lowest set candidate is the one that remains.
        for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/vram_slot_arbiter.sv
// VRAM slot arbiter: on each slot strobe grants the memory port to the display engine
// or one toggle-handshake client, with starvation promotion and a registered memory bus.
module vram_slot_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS  = 4,
    parameter int unsigned ADDR_WIDTH   = 19,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned ID_W = $clog2(NUM_CLIENTS + 1)
) (
    input  logic                            CLK21M,
    input  logic                            RESET,
    input  logic                            slot_strobe,
    input  logic                            display_claim,
    input  logic [ADDR_WIDTH-1:0]           display_addr,
    input  logic [NUM_CLIENTS-1:0]          req_toggle,
    input  logic [NUM_CLIENTS-1:0]          client_we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_wdata,
    input  logic [NUM_CLIENTS*SIZE_W-1:0]   client_size,
    output logic [NUM_CLIENTS-1:0]          ack_toggle,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_we_n,
    output logic [SIZE_W-1:0]               mem_size,
    output logic                            grant_valid,
    output logic [ID_W-1:0]                 grant_id,
    output logic [NUM_CLIENTS-1:0]          starved
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [NUM_CLIENTS-1:0] ack_q, ack_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   we_n_q, we_n_d;
    logic [SIZE_W-1:0]      size_q, size_d;
    logic                   gv_q, gv_d;
    logic [ID_W-1:0]        gid_q, gid_d;
    logic [NUM_CLIENTS-1:0] starved_q, starved_d;
    logic [CNT_W-1:0]       cnt_q [NUM_CLIENTS];
    logic [CNT_W-1:0]       cnt_d [NUM_CLIENTS];

    logic [NUM_CLIENTS-1:0] pending;
    logic [NUM_CLIENTS-1:0] grant_oh;
    logic [ID_W-1:0]        pick_idx;

    assign pending = req_toggle ^ ack_q;

    vram_arb_pick #(
        .NUM_CLIENTS(NUM_CLIENTS)
    ) u_pick (
        .pending  (pending),
        .starved  (starved_q),
        .grant_oh (grant_oh),
        .grant_idx(pick_idx)
    );

    // Slot decision; everything except grant_valid holds outside strobe cycles.
    always_comb begin
        ack_d     = ack_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_n_d    = we_n_q;
        size_d    = size_q;
        gv_d      = 1'b0;
        gid_d     = gid_q;
        starved_d = starved_q;
        cnt_d     = cnt_q;
        if (slot_strobe) begin
            we_n_d = 1'b1;
            for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
                if (!pending[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != LIMIT_C) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            if (display_claim) begin
                addr_d = display_addr;
                gv_d   = 1'b1;
                gid_d  = ID_W'(display_grant_id(NUM_CLIENTS));
            end else if (|pending) begin
                gv_d  = 1'b1;
                gid_d = pick_idx;
                for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
                    if (grant_oh[i]) begin
                        addr_d = client_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        we_n_d = ~client_we[i];
                        if (client_we[i]) begin
                            wdata_d = client_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                            size_d  = client_size[i*SIZE_W +: SIZE_W];
                        end
                        ack_d[i] = ~ack_q[i];
                        cnt_d[i] = '0;
                    end
                end
            end
            for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
                starved_d[i] = (cnt_d[i] == LIMIT_C);
            end
        end
    end

    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            ack_q     <= '0;
            addr_q    <= '1;
            wdata_q   <= '0;
            we_n_q    <= 1'b1;
            size_q    <= MEM_WIDTH_8;
            gv_q      <= 1'b0;
            gid_q     <= '0;
            starved_q <= '0;
            for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ack_q     <= ack_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_n_q    <= we_n_d;
            size_q    <= size_d;
            gv_q      <= gv_d;
            gid_q     <= gid_d;
            starved_q <= starved_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ack_toggle  = ack_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we_n    = we_n_q;
    assign mem_size    = size_q;
    assign grant_valid = gv_q;
    assign grant_id    = gid_q;
    assign starved     = starved_q;

endmodule
